// File: rtl/fb_scan_if.sv
// Frame-buffer scan bus: raster control input plus read strobe/address,
// raster position and display timing outputs of the scan controller.
//
// Handshake: there is no backpressure on this bus. scan_en is a level
// qualifier: while it is 1 the controller advances one raster point per
// clock; while it is 0 every output holds. fb_rd_en is a one-clock read
// strobe: each clock it is 1, fb_addr is a valid address that the RAM must
// accept that clock. fb_addr is don't-care while fb_rd_en is 0.
interface fb_scan_if #(
  parameter int ADDR_W = 17
);
  logic              scan_en;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [10:0]       h_pos;
  logic [9:0]        v_pos;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              img_de;
  logic              frame_start;

  modport master (
    input  scan_en,
    output fb_addr, fb_rd_en, h_pos, v_pos, hsync, vsync, de, img_de, frame_start
  );

  modport slave (
    output scan_en,
    input  fb_addr, fb_rd_en, h_pos, v_pos, hsync, vsync, de, img_de, frame_start
  );
endinterface

// File: rtl/fb_scan_controller.sv
// Frame-buffer scan controller: raster counters, scaled read-address
// sequencing, sync/DE generation, and a delay line that aligns the timing
// outputs with data returned by the frame-buffer RAM.
module fb_scan_controller #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int IMG_W    = 400,
  parameter int IMG_H    = 300,
  parameter int SCALE    = 2,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  fb_scan_if.master  bus
);

  // Raster geometry
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HC_LAST     = 11'(H_TOT - 1);
  localparam logic [10:0] HC_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HC_WIN      = 11'(IMG_W * SCALE);
  localparam logic [10:0] HC_WIN_LAST = 11'(IMG_W * SCALE - 1);

  localparam logic [9:0]  VC_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0]  VC_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VC_WIN      = 10'(IMG_H * SCALE);

  localparam logic [1:0]  SUB_LAST    = 2'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  // Raster counters and address sequencer state
  logic [10:0]       hc_q, hc_d;
  logic [9:0]        vc_q, vc_d;
  logic [1:0]        xs_q, xs_d;
  logic [1:0]        ys_q, ys_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lb_q, lb_d;

  // fb_addr stage registers
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_rd_en_q;
  logic [10:0]       h_pos_q;
  logic [9:0]        v_pos_q;
  logic              frame_start_q;
  logic              hs_s1_q, vs_s1_q, de_s1_q, img_s1_q;

  // RAM-latency delay line for the timing outputs
  logic [RD_LAT-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q, img_pipe_q;

  // Decodes of the current raster point
  logic hc_last, vc_last, win, line_end;
  logic hs_raw, vs_raw, de_raw;

  assign hc_last  = (hc_q == HC_LAST);
  assign vc_last  = (vc_q == VC_LAST);
  assign win      = (hc_q < HC_WIN) && (vc_q < VC_WIN);
  assign line_end = (hc_q == HC_WIN_LAST);
  assign hs_raw   = ((hc_q >= HS_START) && (hc_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_raw   = ((vc_q >= VS_START) && (vc_q < VS_END)) ? VS_POL : ~VS_POL;
  assign de_raw   = (hc_q < HC_ACT) && (vc_q < VC_ACT);

  // Next raster point and next read address; addr_q always holds the
  // address of the point currently addressed by hc_q/vc_q.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    xs_d   = xs_q;
    ys_d   = ys_q;
    addr_d = addr_q;
    lb_d   = lb_q;

    if (hc_last) begin
      hc_d = '0;
      vc_d = vc_last ? '0 : vc_q + 10'd1;
    end else begin
      hc_d = hc_q + 11'd1;
    end

    if (win) begin
      if (line_end) begin
        // Last window pixel of the line: replay the line or move to the next one
        xs_d = '0;
        if (ys_q != SUB_LAST) begin
          ys_d   = ys_q + 2'd1;
          addr_d = lb_q;
        end else begin
          ys_d   = '0;
          lb_d   = lb_q + LINE_STEP;
          addr_d = lb_q + LINE_STEP;
        end
      end else if (xs_q == SUB_LAST) begin
        xs_d   = '0;
        addr_d = addr_q + 1'b1;
      end else begin
        xs_d = xs_q + 2'd1;
      end
    end

    // Frame wrap overrides everything so the image is re-anchored at 0 each frame
    if (hc_last && vc_last) begin
      xs_d   = '0;
      ys_d   = '0;
      addr_d = '0;
      lb_d   = '0;
    end
  end

  // Raster counter and address sequencer registers, frozen while scan_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q   <= '0;
      vc_q   <= '0;
      xs_q   <= '0;
      ys_q   <= '0;
      addr_q <= '0;
      lb_q   <= '0;
    end else if (bus.scan_en) begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      addr_q <= addr_d;
      lb_q   <= lb_d;
    end
  end

  // fb_addr stage: read strobe, address, position and raw timing of the current point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      frame_start_q <= 1'b0;
      hs_s1_q       <= ~HS_POL;
      vs_s1_q       <= ~VS_POL;
      de_s1_q       <= 1'b0;
      img_s1_q      <= 1'b0;
    end else if (bus.scan_en) begin
      // Address only moves inside the window, so it never shows a past-the-end value
      if (win) begin
        fb_addr_q <= addr_q;
      end
      fb_rd_en_q    <= win;
      h_pos_q       <= hc_q;
      v_pos_q       <= vc_q;
      frame_start_q <= (hc_q == 11'd0) && (vc_q == 10'd0);
      hs_s1_q       <= hs_raw;
      vs_s1_q       <= vs_raw;
      de_s1_q       <= de_raw;
      img_s1_q      <= win;
    end
  end

  // Delay line matching the frame-buffer read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe_q  <= {RD_LAT{~HS_POL}};
      vs_pipe_q  <= {RD_LAT{~VS_POL}};
      de_pipe_q  <= '0;
      img_pipe_q <= '0;
    end else if (bus.scan_en) begin
      hs_pipe_q[0]  <= hs_s1_q;
      vs_pipe_q[0]  <= vs_s1_q;
      de_pipe_q[0]  <= de_s1_q;
      img_pipe_q[0] <= img_s1_q;
      for (int i = 1; i < RD_LAT; i++) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        de_pipe_q[i]  <= de_pipe_q[i-1];
        img_pipe_q[i] <= img_pipe_q[i-1];
      end
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_rd_en    = fb_rd_en_q;
  assign bus.h_pos       = h_pos_q;
  assign bus.v_pos       = v_pos_q;
  assign bus.frame_start = frame_start_q;
  assign bus.hsync       = hs_pipe_q[RD_LAT-1];
  assign bus.vsync       = vs_pipe_q[RD_LAT-1];
  assign bus.de          = de_pipe_q[RD_LAT-1];
  assign bus.img_de      = img_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_fb_scan_controller.sv
// Bench for fb_scan_controller on a shrunken raster (24x12 total, 16x8
// active). Instance A: 6x3 image, SCALE=2, RD_LAT=1, active-high syncs.
// Instance B: 12x6 image, SCALE=1, RD_LAT=2, active-low syncs.
module tb_fb_scan_controller;

  localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
  localparam int V_ACT = 8,  V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int HS0 = H_ACT + H_FP, HS1 = H_ACT + H_FP + H_SY;
  localparam int VS0 = V_ACT + V_FP, VS1 = V_ACT + V_FP + V_SY;

  logic clk;
  logic rst_n;
  logic scan_en;

  int k;
  int n_pass;
  int n_checks;
  int fs_cnt;

  logic [43:0] exp_a_q[$];
  logic [43:0] exp_b_q[$];

  fb_scan_if a_if ();
  fb_scan_if b_if ();

  assign a_if.scan_en = scan_en;
  assign b_if.scan_en = scan_en;

  fb_scan_controller #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .IMG_W(6), .IMG_H(3), .SCALE(2), .RD_LAT(1), .ADDR_W(17)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );

  fb_scan_controller #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .IMG_W(12), .IMG_H(6), .SCALE(1), .RD_LAT(2), .ADDR_W(17)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form reference: after k counted edges the fb_addr stage holds raster
  // index k-1, the delayed outputs hold index k-1-lat.
  function automatic logic [43:0] model(int kk, int lat, int iw, int ih, int sc, bit hp, bit vp);
    logic rd, fs, hs, vs, de, img;
    logic [16:0] a;
    logic [10:0] ho;
    logic [9:0]  vo;
    int n, h, v;
    rd = 1'b0; fs = 1'b0; a = '0; ho = '0; vo = '0;
    hs = ~hp; vs = ~vp; de = 1'b0; img = 1'b0;
    if (kk >= 1) begin
      n  = kk - 1;
      h  = n % H_TOT;
      v  = (n / H_TOT) % V_TOT;
      rd = (h < iw * sc) && (v < ih * sc);
      if (rd) a = 17'((v / sc) * iw + h / sc);
      ho = 11'(h);
      vo = 10'(v);
      fs = (h == 0) && (v == 0);
    end
    if (kk >= 1 + lat) begin
      n   = kk - 1 - lat;
      h   = n % H_TOT;
      v   = (n / H_TOT) % V_TOT;
      hs  = (h >= HS0 && h < HS1) ? hp : ~hp;
      vs  = (v >= VS0 && v < VS1) ? vp : ~vp;
      de  = (h < H_ACT) && (v < V_ACT);
      img = (h < iw * sc) && (v < ih * sc);
    end
    return {rd, a, ho, vo, fs, hs, vs, de, img};
  endfunction

  function automatic logic [43:0] act_a();
    return {a_if.fb_rd_en, a_if.fb_rd_en ? a_if.fb_addr : 17'd0, a_if.h_pos, a_if.v_pos,
            a_if.frame_start, a_if.hsync, a_if.vsync, a_if.de, a_if.img_de};
  endfunction

  function automatic logic [43:0] act_b();
    return {b_if.fb_rd_en, b_if.fb_rd_en ? b_if.fb_addr : 17'd0, b_if.h_pos, b_if.v_pos,
            b_if.frame_start, b_if.hsync, b_if.vsync, b_if.de, b_if.img_de};
  endfunction

  // Scoreboard compare helpers
  task automatic check_v(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s got=%h exp=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic sample(input string tag);
    logic [43:0] ea, eb;
    exp_a_q.push_back(model(k, 1, 6, 3, 2, 1'b1, 1'b1));
    exp_b_q.push_back(model(k, 2, 12, 6, 1, 1'b0, 1'b0));
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    check_v($sformatf("%s_a k=%0d", tag, k), act_a(), ea);
    check_v($sformatf("%s_b k=%0d", tag, k), act_b(), eb);
  endtask

  // Drivers
  task automatic step(input bit en);
    scan_en = en;
    @(posedge clk);
    if (en && rst_n) k++;
    @(negedge clk);
    if (a_if.frame_start) fs_cnt++;
    sample("cyc");
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en);
  endtask

  // Directed vectors for instance A
  typedef struct {
    int          adv;
    logic [16:0] addr;
    bit          rd;
    int          h;
    int          v;
    bit          fs, hs, vs, de, img;
  } vec_t;

  function automatic vec_t mk(int adv, int addr, bit rd, int h, int v,
                              bit fs, bit hs, bit vs, bit de, bit img);
    vec_t r;
    r.adv = adv; r.addr = 17'(addr); r.rd = rd; r.h = h; r.v = v;
    r.fs = fs; r.hs = hs; r.vs = vs; r.de = de; r.img = img;
    return r;
  endfunction

  vec_t tbl[17];

  initial begin
    logic [43:0] ev;

    //            adv addr rd  h  v  fs hs vs de img
    tbl[0]  = mk(  1,   0, 1,  0, 0, 1, 0, 0, 0, 0);  // (0,0) enters, frame_start
    tbl[1]  = mk(  1,   0, 1,  1, 0, 0, 0, 0, 1, 1);  // pixel held for SCALE clocks
    tbl[2]  = mk(  1,   1, 1,  2, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(  9,   5, 1, 11, 0, 0, 0, 0, 1, 1);  // last window pixel of line 0
    tbl[4]  = mk(  1,   0, 0, 12, 0, 0, 0, 0, 1, 1);  // window ends
    tbl[5]  = mk(  1,   0, 0, 13, 0, 0, 0, 0, 1, 0);  // de high, img_de low
    tbl[6]  = mk(  5,   0, 0, 18, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(  1,   0, 0, 19, 0, 0, 1, 0, 0, 0);  // hsync starts
    tbl[8]  = mk(  3,   0, 0, 22, 0, 0, 0, 0, 0, 0);  // hsync 3 clocks wide
    tbl[9]  = mk(  3,   0, 1,  1, 1, 0, 0, 0, 1, 1);  // line 1 replays line 0
    tbl[10] = mk( 24,   6, 1,  1, 2, 0, 0, 0, 1, 1);  // line 2 starts at IMG_W
    tbl[11] = mk( 82,  17, 1, 11, 5, 0, 0, 0, 1, 1);  // last image address
    tbl[12] = mk( 24,   0, 0, 11, 6, 0, 0, 0, 1, 0);  // below window
    tbl[13] = mk( 61,   0, 0,  0, 9, 0, 0, 0, 0, 0);
    tbl[14] = mk(  1,   0, 0,  1, 9, 0, 0, 1, 0, 0);  // vsync starts
    tbl[15] = mk( 71,   0, 1,  0, 0, 1, 0, 0, 0, 0);  // next frame at addr 0
    tbl[16] = mk(  1,   0, 1,  1, 0, 0, 0, 0, 1, 1);

    n_pass = 0; n_checks = 0; fs_cnt = 0; k = 0;
    scan_en = 1'b0;
    rst_n   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    sample("rst");
    check_i("rst_a_addr", int'(a_if.fb_addr), 0);
    check_i("rst_a_hsync", int'(a_if.hsync), 0);
    check_i("rst_b_hsync", int'(b_if.hsync), 1);
    check_i("rst_b_vsync", int'(b_if.vsync), 1);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      run(tbl[i].adv, 1'b1);
      ev = {tbl[i].rd, tbl[i].rd ? tbl[i].addr : 17'd0, 11'(tbl[i].h), 10'(tbl[i].v),
            tbl[i].fs, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].img};
      check_v($sformatf("vec%0d", i), act_a(), ev);
    end

    // scan_en freeze at (6,2) of the second frame
    run(53, 1'b1);
    check_i("pre_freeze_addr", int'(a_if.fb_addr), 9);
    check_i("pre_freeze_hpos", int'(a_if.h_pos), 6);
    run(10, 1'b0);
    check_i("frozen_addr", int'(a_if.fb_addr), 9);
    check_i("frozen_hpos", int'(a_if.h_pos), 6);
    check_i("frozen_vpos", int'(a_if.v_pos), 2);
    run(2, 1'b1);
    check_i("resume_addr", int'(a_if.fb_addr), 10);
    check_i("resume_hpos", int'(a_if.h_pos), 8);

    // One frame_start across the next frame boundary
    fs_cnt = 0;
    run(255, 1'b1);
    check_i("fs_count", fs_cnt, 1);

    // Asynchronous reset mid-frame
    run(50, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_v("async_rst_a", act_a(), model(0, 1, 6, 3, 2, 1'b1, 1'b1));
    check_v("async_rst_b", act_b(), model(0, 2, 12, 6, 1, 1'b0, 1'b0));
    check_i("async_rst_addr", int'(a_if.fb_addr), 0);
    k = 0;
    @(posedge clk);
    @(negedge clk);
    sample("rst_hold");
    rst_n = 1'b1;

    step(1'b1);
    check_i("post_rst_addr", int'(a_if.fb_addr), 0);
    check_i("post_rst_fs", int'(a_if.frame_start), 1);
    check_i("post_rst_b_fs", int'(b_if.frame_start), 1);
    check_i("b_rd_lead", int'(b_if.fb_rd_en), 1);
    check_i("b_de_lag", int'(b_if.de), 0);
    run(2, 1'b1);
    check_i("b_de_after2", int'(b_if.de), 1);
    check_i("b_img_after2", int'(b_if.img_de), 1);
    run(12, 1'b1);
    check_i("b_de_outside", int'(b_if.de), 1);
    check_i("b_img_outside", int'(b_if.img_de), 0);
    run(6, 1'b1);
    check_i("b_hsync_low", int'(b_if.hsync), 0);
    run(111, 1'b1);
    check_i("b_last_addr", int'(b_if.fb_addr), 71);
    check_i("b_last_rd", int'(b_if.fb_rd_en), 1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
